goe_trig_ctrl: RTL and testbench

//  Consumes the 2-bit goe summary from the GEN_GOE LUT tree and the 256-bit raw trigger vector.

---
 rtl/goe_trig_ctrl.sv | 176 +++++++++++++++++
 tb/tb_goe_trig_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/goe_trig_ctrl.sv
// goe_trig_ctrl: synchronises the GEN_GOE summary and raw trigger vector, qualifies goe edges by mode,
// and offers each event to the packet builder with MAROC hold and holdoff. Option macro: GOE_DROP_CNT_EN.
module goe_trig_ctrl #(
    parameter int NPIX      = 256,
    parameter int HOLDOFF_W = 16,
    parameter int EVCNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           goe,
    input  logic [NPIX-1:0]      trigger,
    input  logic [1:0]           mode,
    input  logic [HOLDOFF_W-1:0] holdoff,
    output logic                 hold_out,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [NPIX-1:0]      ev_pattern,
    output logic [1:0]           ev_type,
    output logic [EVCNT_W-1:0]   ev_count,
    output logic                 busy
`ifdef GOE_DROP_CNT_EN
    ,
    output logic [15:0]          drop_count
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        HOLDOFF  = 2'd2
    } state_t;

    localparam logic [HOLDOFF_W-1:0] HOLD_ONE = {{(HOLDOFF_W-1){1'b0}}, 1'b1};
    localparam logic [EVCNT_W-1:0]   EV_ONE   = {{(EVCNT_W-1){1'b0}}, 1'b1};

    logic [1:0]           goeMeta_q, goeSync_q;
    logic [NPIX-1:0]      trigMeta_q, trigSync_q;
    logic [1:0]           syncFill_q;
    logic                 armed_q, armed_d;
    logic                 trigDly_q;
    logic                 trigSel, trigRise, fire, accept;

    state_t               state_q, state_d;
    logic [HOLDOFF_W-1:0] holdCnt_q, holdCnt_d;
    logic                 holdOut_q, holdOut_d;
    logic                 evValid_q, evValid_d;
    logic [NPIX-1:0]      evPattern_q, evPattern_d;
    logic [1:0]           evType_q, evType_d;
    logic [EVCNT_W-1:0]   evCount_q, evCount_d;

    // Two-flop synchronisers; syncFill_q marks when goeSync_q holds a real post-reset sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            goeMeta_q  <= '0;
            goeSync_q  <= '0;
            trigMeta_q <= '0;
            trigSync_q <= '0;
            syncFill_q <= '0;
            armed_q    <= 1'b0;
            trigDly_q  <= 1'b0;
        end else begin
            goeMeta_q  <= goe;
            goeSync_q  <= goeMeta_q;
            trigMeta_q <= trigger;
            trigSync_q <= trigMeta_q;
            syncFill_q <= {syncFill_q[0], 1'b1};
            armed_q    <= armed_d;
            trigDly_q  <= trigSel;
        end
    end

    // A goe level already high at reset release is not an edge: firing waits until trigSel is seen low.
    always_comb begin
        trigSel = 1'b0;
        case (mode)
            2'b01:   trigSel = goeSync_q[0];
            2'b10:   trigSel = goeSync_q[1];
            2'b11:   trigSel = goeSync_q[0] | goeSync_q[1];
            default: trigSel = 1'b0;
        endcase
        armed_d  = armed_q | (syncFill_q[1] & ~trigSel);
        trigRise = trigSel & ~trigDly_q;
        fire     = (state_q == IDLE) & armed_q & trigRise;
        accept   = evValid_q & ev_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            holdCnt_q   <= '0;
            holdOut_q   <= 1'b0;
            evValid_q   <= 1'b0;
            evPattern_q <= '0;
            evType_q    <= '0;
            evCount_q   <= '0;
        end else begin
            state_q     <= state_d;
            holdCnt_q   <= holdCnt_d;
            holdOut_q   <= holdOut_d;
            evValid_q   <= evValid_d;
            evPattern_q <= evPattern_d;
            evType_q    <= evType_d;
            evCount_q   <= evCount_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        holdCnt_d   = holdCnt_q;
        holdOut_d   = holdOut_q;
        evValid_d   = evValid_q;
        evPattern_d = evPattern_q;
        evType_d    = evType_q;
        evCount_d   = evCount_q;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    evPattern_d = trigSync_q;
                    evType_d    = goeSync_q;
                    evValid_d   = 1'b1;
                    holdOut_d   = 1'b1;
                    state_d     = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (accept) begin
                    evValid_d = 1'b0;
                    evCount_d = evCount_q + EV_ONE;
                    if (holdoff == '0) begin
                        holdOut_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        holdCnt_d = holdoff - HOLD_ONE;
                        state_d   = HOLDOFF;
                    end
                end
            end
            HOLDOFF: begin
                if (holdCnt_q == '0) begin
                    holdOut_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    holdCnt_d = holdCnt_q - HOLD_ONE;
                end
            end
            default: begin
                evValid_d = 1'b0;
                holdOut_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

`ifdef GOE_DROP_CNT_EN
    logic [15:0] dropCnt_q;

    // Counts qualifying edges that arrive while an event is still in progress; saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropCnt_q <= '0;
        end else if ((state_q != IDLE) && trigRise && (dropCnt_q != 16'hFFFF)) begin
            dropCnt_q <= dropCnt_q + 16'd1;
        end
    end

    assign drop_count = dropCnt_q;
`endif

    assign hold_out   = holdOut_q;
    assign ev_valid   = evValid_q;
    assign ev_pattern = evPattern_q;
    assign ev_type    = evType_q;
    assign ev_count   = evCount_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_goe_trig_ctrl.sv
// tb_goe_trig_ctrl: directed vector table plus hand-written multi-cycle sequences for goe_trig_ctrl.
// Checks drop_count as well when GOE_DROP_CNT_EN is defined.
module tb_goe_trig_ctrl;

    logic         clk;
    logic         rst_n;
    logic [1:0]   goe;
    logic [255:0] trigger;
    logic [1:0]   mode;
    logic [15:0]  holdoff;
    logic         hold_out;
    logic         ev_valid;
    logic         ev_ready;
    logic [255:0] ev_pattern;
    logic [1:0]   ev_type;
    logic [31:0]  ev_count;
    logic         busy;
`ifdef GOE_DROP_CNT_EN
    logic [15:0]  drop_count;
`endif

    int checks = 0;
    int failures = 0;

    localparam logic [255:0] WIDE = {1'b1, 254'd0, 1'b1};

    typedef struct {
        logic [1:0]   goe;
        logic [255:0] trig;
        logic [1:0]   mode;
        logic [15:0]  holdoff;
        logic         ready;
        int           cycles;
        logic         expValid;
        logic         expHold;
        logic         expBusy;
        logic [255:0] expPattern;
        logic [1:0]   expType;
        logic [31:0]  expCount;
    } vec_t;

    vec_t vecs [18];

    goe_trig_ctrl #(.NPIX(256), .HOLDOFF_W(16), .EVCNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .goe        (goe),
        .trigger    (trigger),
        .mode       (mode),
        .holdoff    (holdoff),
        .hold_out   (hold_out),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_pattern (ev_pattern),
        .ev_type    (ev_type),
        .ev_count   (ev_count),
        .busy       (busy)
`ifdef GOE_DROP_CNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic stepClk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic v, input logic h, input logic b,
                            input logic [255:0] pat, input logic [1:0] typ, input logic [31:0] cnt);
        checkOutput({tag, ".ev_valid"},   256'(ev_valid),   256'(v));
        checkOutput({tag, ".hold_out"},   256'(hold_out),   256'(h));
        checkOutput({tag, ".busy"},       256'(busy),       256'(b));
        checkOutput({tag, ".ev_pattern"}, ev_pattern,       pat);
        checkOutput({tag, ".ev_type"},    256'(ev_type),    256'(typ));
        checkOutput({tag, ".ev_count"},   256'(ev_count),   256'(cnt));
    endtask

    task automatic applyStimulus(input vec_t v);
        goe      = v.goe;
        trigger  = v.trig;
        mode     = v.mode;
        holdoff  = v.holdoff;
        ev_ready = v.ready;
        stepClk(v.cycles);
    endtask

    initial begin
        // goe mode trig'd            mode  hold   rdy cyc  V     H     B     pattern  type   count
        vecs[0]  = '{2'b01, 256'h5,   2'b01, 16'd0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 256'h0,  2'b00, 32'd0};
        vecs[1]  = '{2'b01, 256'h5,   2'b01, 16'd0, 1'b1, 1, 1'b1, 1'b1, 1'b1, 256'h5,  2'b01, 32'd0};
        vecs[2]  = '{2'b01, 256'h5,   2'b01, 16'd0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 256'h5,  2'b01, 32'd1};
        vecs[3]  = '{2'b01, 256'h5,   2'b01, 16'd0, 1'b1, 4, 1'b0, 1'b0, 1'b0, 256'h5,  2'b01, 32'd1};
        vecs[4]  = '{2'b00, 256'h0,   2'b01, 16'd0, 1'b1, 4, 1'b0, 1'b0, 1'b0, 256'h5,  2'b01, 32'd1};
        vecs[5]  = '{2'b01, 256'hA,   2'b10, 16'd0, 1'b1, 5, 1'b0, 1'b0, 1'b0, 256'h5,  2'b01, 32'd1};
        vecs[6]  = '{2'b00, 256'h0,   2'b10, 16'd0, 1'b1, 4, 1'b0, 1'b0, 1'b0, 256'h5,  2'b01, 32'd1};
        vecs[7]  = '{2'b10, 256'h30,  2'b10, 16'd0, 1'b1, 3, 1'b1, 1'b1, 1'b1, 256'h30, 2'b10, 32'd1};
        vecs[8]  = '{2'b10, 256'h30,  2'b10, 16'd0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 256'h30, 2'b10, 32'd2};
        vecs[9]  = '{2'b00, 256'h0,   2'b10, 16'd0, 1'b1, 4, 1'b0, 1'b0, 1'b0, 256'h30, 2'b10, 32'd2};
        vecs[10] = '{2'b10, WIDE,     2'b11, 16'd0, 1'b1, 3, 1'b1, 1'b1, 1'b1, WIDE,    2'b10, 32'd2};
        vecs[11] = '{2'b10, WIDE,     2'b11, 16'd0, 1'b1, 1, 1'b0, 1'b0, 1'b0, WIDE,    2'b10, 32'd3};
        vecs[12] = '{2'b00, 256'h0,   2'b11, 16'd0, 1'b1, 4, 1'b0, 1'b0, 1'b0, WIDE,    2'b10, 32'd3};
        vecs[13] = '{2'b11, 256'hFF,  2'b00, 16'd0, 1'b1, 6, 1'b0, 1'b0, 1'b0, WIDE,    2'b10, 32'd3};
        vecs[14] = '{2'b00, 256'h0,   2'b00, 16'd0, 1'b1, 4, 1'b0, 1'b0, 1'b0, WIDE,    2'b10, 32'd3};
        vecs[15] = '{2'b01, 256'h1,   2'b11, 16'd0, 1'b1, 3, 1'b1, 1'b1, 1'b1, 256'h1,  2'b01, 32'd3};
        vecs[16] = '{2'b00, 256'h0,   2'b01, 16'd0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 256'h1,  2'b01, 32'd4};
        vecs[17] = '{2'b00, 256'h0,   2'b01, 16'd0, 1'b1, 4, 1'b0, 1'b0, 1'b0, 256'h1,  2'b01, 32'd4};

        // Reset with goe already high: nothing may fire until goe falls and rises again.
        rst_n    = 1'b0;
        goe      = 2'b01;
        mode     = 2'b01;
        trigger  = 256'h0;
        holdoff  = 16'd0;
        ev_ready = 1'b1;
        stepClk(3);
        checkAll("reset", 1'b0, 1'b0, 1'b0, 256'h0, 2'b00, 32'd0);
`ifdef GOE_DROP_CNT_EN
        checkOutput("reset.drop_count", 256'(drop_count), 256'd0);
`endif
        rst_n = 1'b1;
        stepClk(8);
        checkAll("steady_high", 1'b0, 1'b0, 1'b0, 256'h0, 2'b00, 32'd0);
        goe = 2'b00;
        stepClk(4);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i]);
            checkAll($sformatf("v%0d", i), vecs[i].expValid, vecs[i].expHold, vecs[i].expBusy,
                     vecs[i].expPattern, vecs[i].expType, vecs[i].expCount);
        end

        // Backpressure: event held stable while ev_ready is low.
        mode     = 2'b01;
        ev_ready = 1'b0;
        goe      = 2'b01;
        trigger  = 256'hDEAD;
        stepClk(3);
        checkAll("bp_rise", 1'b1, 1'b1, 1'b1, 256'hDEAD, 2'b01, 32'd4);
        goe     = 2'b00;
        trigger = 256'h0;
        for (int i = 0; i < 10; i++) begin
            stepClk(1);
            checkAll($sformatf("bp_hold%0d", i), 1'b1, 1'b1, 1'b1, 256'hDEAD, 2'b01, 32'd4);
        end
        ev_ready = 1'b1;
        stepClk(1);
        checkAll("bp_accept", 1'b0, 1'b0, 1'b0, 256'hDEAD, 2'b01, 32'd5);
        stepClk(3);
        checkAll("ready_idle", 1'b0, 1'b0, 1'b0, 256'hDEAD, 2'b01, 32'd5);

        // Holdoff of 5 with a goe re-trigger inside the window.
        holdoff = 16'd5;
        goe     = 2'b01;
        trigger = 256'h9;
        stepClk(3);
        checkAll("ho_fire", 1'b1, 1'b1, 1'b1, 256'h9, 2'b01, 32'd5);
        stepClk(1);
        checkAll("ho_accept", 1'b0, 1'b1, 1'b1, 256'h9, 2'b01, 32'd6);
        goe = 2'b00;
        stepClk(1);
        checkAll("ho_c1", 1'b0, 1'b1, 1'b1, 256'h9, 2'b01, 32'd6);
        goe = 2'b01;
        for (int i = 2; i <= 4; i++) begin
            stepClk(1);
            checkAll($sformatf("ho_c%0d", i), 1'b0, 1'b1, 1'b1, 256'h9, 2'b01, 32'd6);
        end
        stepClk(1);
        checkAll("ho_end", 1'b0, 1'b0, 1'b0, 256'h9, 2'b01, 32'd6);
        stepClk(5);
        checkAll("ho_dropped", 1'b0, 1'b0, 1'b0, 256'h9, 2'b01, 32'd6);
`ifdef GOE_DROP_CNT_EN
        checkOutput("ho.drop_count", 256'(drop_count), 256'd1);
`endif
        holdoff = 16'd0;
        goe     = 2'b00;
        stepClk(4);

        // Asynchronous reset in WAIT_ACK, then a normal event after release.
        ev_ready = 1'b0;
        goe      = 2'b01;
        trigger  = 256'h3;
        stepClk(3);
        checkAll("rst_pre", 1'b1, 1'b1, 1'b1, 256'h3, 2'b01, 32'd6);
        #2;
        rst_n    = 1'b0;
        goe      = 2'b00;
        ev_ready = 1'b1;
        #1;
        checkAll("rst_async", 1'b0, 1'b0, 1'b0, 256'h0, 2'b00, 32'd0);
        stepClk(2);
        rst_n = 1'b1;
        stepClk(5);
        goe     = 2'b01;
        trigger = 256'h11;
        stepClk(2);
        checkAll("post_rst_wait", 1'b0, 1'b0, 1'b0, 256'h0, 2'b00, 32'd0);
        stepClk(1);
        checkAll("post_rst_fire", 1'b1, 1'b1, 1'b1, 256'h11, 2'b01, 32'd0);
        stepClk(1);
        checkAll("post_rst_accept", 1'b0, 1'b0, 1'b0, 256'h11, 2'b01, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
